// File: rtl/decode_stage_pkg.sv
// Shared instruction IDs, opcode constants and the decoded-instruction record
// used by the decode core and the registered decode stage.
package decode_stage_pkg;

  localparam logic [5:0] INSTR_ADD     = 6'd1;
  localparam logic [5:0] INSTR_SUB     = 6'd2;
  localparam logic [5:0] INSTR_XOR     = 6'd3;
  localparam logic [5:0] INSTR_OR      = 6'd4;
  localparam logic [5:0] INSTR_AND     = 6'd5;
  localparam logic [5:0] INSTR_SLL     = 6'd6;
  localparam logic [5:0] INSTR_SRL     = 6'd7;
  localparam logic [5:0] INSTR_SRA     = 6'd8;
  localparam logic [5:0] INSTR_SLT     = 6'd9;
  localparam logic [5:0] INSTR_SLTU    = 6'd10;
  localparam logic [5:0] INSTR_ADDI    = 6'd11;
  localparam logic [5:0] INSTR_XORI    = 6'd12;
  localparam logic [5:0] INSTR_ORI     = 6'd13;
  localparam logic [5:0] INSTR_ANDI    = 6'd14;
  localparam logic [5:0] INSTR_SLLI    = 6'd15;
  localparam logic [5:0] INSTR_SRLI    = 6'd16;
  localparam logic [5:0] INSTR_SRAI    = 6'd17;
  localparam logic [5:0] INSTR_SLTI    = 6'd18;
  localparam logic [5:0] INSTR_SLTIU   = 6'd19;
  localparam logic [5:0] INSTR_LB      = 6'd20;
  localparam logic [5:0] INSTR_LH      = 6'd21;
  localparam logic [5:0] INSTR_LW      = 6'd22;
  localparam logic [5:0] INSTR_LBU     = 6'd23;
  localparam logic [5:0] INSTR_LHU     = 6'd24;
  localparam logic [5:0] INSTR_SB      = 6'd25;
  localparam logic [5:0] INSTR_SH      = 6'd26;
  localparam logic [5:0] INSTR_SW      = 6'd27;
  localparam logic [5:0] INSTR_BEQ     = 6'd28;
  localparam logic [5:0] INSTR_BNE     = 6'd29;
  localparam logic [5:0] INSTR_BLT     = 6'd30;
  localparam logic [5:0] INSTR_BGE     = 6'd31;
  localparam logic [5:0] INSTR_BLTU    = 6'd32;
  localparam logic [5:0] INSTR_BGEU    = 6'd33;
  localparam logic [5:0] INSTR_JAL     = 6'd34;
  localparam logic [5:0] INSTR_JALR    = 6'd35;
  localparam logic [5:0] INSTR_LUI     = 6'd36;
  localparam logic [5:0] INSTR_AUIPC   = 6'd37;
  localparam logic [5:0] INSTR_FENCE   = 6'd38;
  localparam logic [5:0] INSTR_FENCE_I = 6'd39;
  // M-ops occupy 40..47 in funct3 order so the core can form the ID as {3'b101, funct3}
  localparam logic [5:0] INSTR_MUL     = 6'd40;
  localparam logic [5:0] INSTR_MULH    = 6'd41;
  localparam logic [5:0] INSTR_MULHSU  = 6'd42;
  localparam logic [5:0] INSTR_MULHU   = 6'd43;
  localparam logic [5:0] INSTR_DIV     = 6'd44;
  localparam logic [5:0] INSTR_DIVU    = 6'd45;
  localparam logic [5:0] INSTR_REM     = 6'd46;
  localparam logic [5:0] INSTR_REMU    = 6'd47;
  localparam logic [5:0] INSTR_CSRRW   = 6'd48;
  localparam logic [5:0] INSTR_CSRRS   = 6'd49;
  localparam logic [5:0] INSTR_CSRRC   = 6'd50;
  localparam logic [5:0] INSTR_CSRRWI  = 6'd51;
  localparam logic [5:0] INSTR_CSRRSI  = 6'd52;
  localparam logic [5:0] INSTR_CSRRCI  = 6'd53;
  localparam logic [5:0] INSTR_ECALL   = 6'd54;
  localparam logic [5:0] INSTR_EBREAK  = 6'd55;
  localparam logic [5:0] INSTR_MRET    = 6'd56;
  localparam logic [5:0] INSTR_INVALID = 6'd63;

  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [5:0]  instr_id;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        rd_valid;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_core.sv
// Purely combinational RV32I(+M, +Zicsr) decoder: instruction word to ID,
// register fields, valid flags and extended immediate.
module decode_core
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1,
  parameter bit SUPPRESS_X0  = 1'b1
) (
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] immI, immS, immB, immU, immJ, immCsr;
  logic [5:0]  id;
  logic        useRs1, useRs2, useRd, keepUimm;
  logic [31:0] imm;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign immI   = {{20{instr_i[31]}}, instr_i[31:20]};
  assign immS   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign immB   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign immU   = {instr_i[31:12], 12'h000};
  assign immJ   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign immCsr = {20'h00000, instr_i[31:20]};

  always_comb begin
    id       = INSTR_INVALID;
    useRs1   = 1'b0;
    useRs2   = 1'b0;
    useRd    = 1'b0;
    keepUimm = 1'b0;
    imm      = 32'h0;
    unique case (opcode)
      OPC_OP: begin
        {useRs1, useRs2, useRd} = 3'b111;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: id = INSTR_ADD;
            3'd1: id = INSTR_SLL;
            3'd2: id = INSTR_SLT;
            3'd3: id = INSTR_SLTU;
            3'd4: id = INSTR_XOR;
            3'd5: id = INSTR_SRL;
            3'd6: id = INSTR_OR;
            default: id = INSTR_AND;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) id = INSTR_SUB;
          else if (f3 == 3'd5) id = INSTR_SRA;
        end else if (f7 == 7'h01 && ENABLE_M) begin
          id = {3'b101, f3};
        end
      end
      OPC_OP_IMM: begin
        {useRs1, useRd} = 2'b11;
        imm = immI;
        case (f3)
          3'd0: id = INSTR_ADDI;
          3'd2: id = INSTR_SLTI;
          3'd3: id = INSTR_SLTIU;
          3'd4: id = INSTR_XORI;
          3'd6: id = INSTR_ORI;
          3'd7: id = INSTR_ANDI;
          3'd1: if (f7 == 7'h00) id = INSTR_SLLI;
          default: begin
            if (f7 == 7'h00) id = INSTR_SRLI;
            else if (f7 == 7'h20) id = INSTR_SRAI;
          end
        endcase
      end
      OPC_LOAD: begin
        {useRs1, useRd} = 2'b11;
        imm = immI;
        case (f3)
          3'd0: id = INSTR_LB;
          3'd1: id = INSTR_LH;
          3'd2: id = INSTR_LW;
          3'd4: id = INSTR_LBU;
          3'd5: id = INSTR_LHU;
          default: id = INSTR_INVALID;
        endcase
      end
      OPC_STORE: begin
        {useRs1, useRs2} = 2'b11;
        imm = immS;
        case (f3)
          3'd0: id = INSTR_SB;
          3'd1: id = INSTR_SH;
          3'd2: id = INSTR_SW;
          default: id = INSTR_INVALID;
        endcase
      end
      OPC_BRANCH: begin
        {useRs1, useRs2} = 2'b11;
        imm = immB;
        case (f3)
          3'd0: id = INSTR_BEQ;
          3'd1: id = INSTR_BNE;
          3'd4: id = INSTR_BLT;
          3'd5: id = INSTR_BGE;
          3'd6: id = INSTR_BLTU;
          3'd7: id = INSTR_BGEU;
          default: id = INSTR_INVALID;
        endcase
      end
      OPC_JAL: begin
        useRd = 1'b1;
        imm   = immJ;
        id    = INSTR_JAL;
      end
      OPC_JALR: begin
        {useRs1, useRd} = 2'b11;
        imm = immI;
        if (f3 == 3'd0) id = INSTR_JALR;
      end
      OPC_LUI: begin
        useRd = 1'b1;
        imm   = immU;
        id    = INSTR_LUI;
      end
      OPC_AUIPC: begin
        useRd = 1'b1;
        imm   = immU;
        id    = INSTR_AUIPC;
      end
      OPC_MISC_MEM: begin
        if (f3 == 3'd0) id = INSTR_FENCE;
        else if (f3 == 3'd1) id = INSTR_FENCE_I;
      end
      OPC_SYSTEM: begin
        if (ENABLE_ZICSR) begin
          // The *I variants reuse the rs1 slot for the 5-bit uimm, which is not a register read
          case (f3)
            3'd0: begin
              imm = immI;
              if (instr_i == 32'h00000073) id = INSTR_ECALL;
              else if (instr_i == 32'h00100073) id = INSTR_EBREAK;
              else if (instr_i == 32'h30200073) id = INSTR_MRET;
            end
            3'd1, 3'd2, 3'd3: begin
              {useRs1, useRd} = 2'b11;
              imm = immCsr;
              id  = INSTR_CSRRW + {4'd0, f3[1:0]} - 6'd1;
            end
            3'd5, 3'd6, 3'd7: begin
              {keepUimm, useRd} = 2'b11;
              imm = immCsr;
              id  = INSTR_CSRRWI + {4'd0, f3[1:0]} - 6'd1;
            end
            default: id = INSTR_INVALID;
          endcase
        end
      end
      default: id = INSTR_INVALID;
    endcase
  end

  always_comb begin
    dec_o          = '0;
    dec_o.instr_id = id;
    dec_o.opcode   = opcode;
    dec_o.illegal  = (id == INSTR_INVALID);
    if (!dec_o.illegal) begin
      dec_o.imm       = imm;
      dec_o.rs1       = (useRs1 || keepUimm) ? instr_i[19:15] : 5'd0;
      dec_o.rs2       = useRs2 ? instr_i[24:20] : 5'd0;
      dec_o.rd        = useRd ? instr_i[11:7] : 5'd0;
      dec_o.rs1_valid = useRs1;
      dec_o.rs2_valid = useRs2;
      dec_o.rd_valid  = useRd && !(SUPPRESS_X0 && instr_i[11:7] == 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode core feeding an output register (OR) backed
// by a one-entry skid register (SR), with valid/ready on both sides and flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1,
  parameter bit SUPPRESS_X0  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [5:0]          out_instr_id,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_rs1_valid,
  output logic                out_rs2_valid,
  output logic                out_rd_valid,
  output logic [31:0]         out_imm,
  output logic                out_illegal
);

  decoded_t              inDec;
  decoded_t              or_dec_q, or_dec_d, sr_dec_q, sr_dec_d;
  logic [PC_WIDTH-1:0]   or_pc_q, or_pc_d, sr_pc_q, sr_pc_d;
  logic                  or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
  logic                  accept, orFree;

  decode_core #(
    .ENABLE_M    (ENABLE_M),
    .ENABLE_ZICSR(ENABLE_ZICSR),
    .SUPPRESS_X0 (SUPPRESS_X0)
  ) u_core (
    .instr_i(in_instr),
    .dec_o  (inDec)
  );

  // in_ready comes straight from the SR flop, so accepting never waits on out_ready
  assign accept = in_valid && !sr_valid_q && !flush;
  assign orFree = !or_valid_q || out_ready;

  always_comb begin
    or_dec_d   = or_dec_q;
    or_pc_d    = or_pc_q;
    or_valid_d = or_valid_q;
    sr_dec_d   = sr_dec_q;
    sr_pc_d    = sr_pc_q;
    sr_valid_d = sr_valid_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (orFree) begin
      if (sr_valid_q) begin
        or_dec_d   = sr_dec_q;
        or_pc_d    = sr_pc_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else begin
        or_valid_d = accept;
        if (accept) begin
          or_dec_d = inDec;
          or_pc_d  = in_pc;
        end
      end
    end else if (accept) begin
      sr_dec_d   = inDec;
      sr_pc_d    = in_pc;
      sr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_dec_q   <= '0;
      or_pc_q    <= '0;
      or_valid_q <= 1'b0;
      sr_dec_q   <= '0;
      sr_pc_q    <= '0;
      sr_valid_q <= 1'b0;
    end else begin
      or_dec_q   <= or_dec_d;
      or_pc_q    <= or_pc_d;
      or_valid_q <= or_valid_d;
      sr_dec_q   <= sr_dec_d;
      sr_pc_q    <= sr_pc_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  assign in_ready      = !sr_valid_q;
  assign out_valid     = or_valid_q;
  assign out_pc        = or_pc_q;
  assign out_instr_id  = or_dec_q.instr_id;
  assign out_opcode    = or_dec_q.opcode;
  assign out_rs1       = or_dec_q.rs1;
  assign out_rs2       = or_dec_q.rs2;
  assign out_rd        = or_dec_q.rd;
  assign out_rs1_valid = or_dec_q.rs1_valid;
  assign out_rs2_valid = or_dec_q.rs2_valid;
  assign out_rd_valid  = or_dec_q.rd_valid;
  assign out_imm       = or_dec_q.imm;
  assign out_illegal   = or_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of instruction vectors fed through a scoreboard,
// plus backpressure, flush and mid-stream reset sequences.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  vld;
    logic [31:0] imm;
    logic [5:0]  altId;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } sb_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [5:0]  out_instr_id;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_valid, out_rs2_valid, out_rd_valid, out_illegal;

  logic        alt_in_ready, alt_out_valid;
  logic [31:0] alt_out_pc, alt_out_imm;
  logic [5:0]  alt_out_instr_id;
  logic [6:0]  alt_out_opcode;
  logic [4:0]  alt_out_rs1, alt_out_rs2, alt_out_rd;
  logic        alt_out_rs1_valid, alt_out_rs2_valid, alt_out_rd_valid, alt_out_illegal;

  int  checks = 0;
  int  passes = 0;
  int  lastWait = 0;
  sb_t sbQ[$];
  vec_t vecs[$];

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1), .SUPPRESS_X0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr_id(out_instr_id), .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_rd_valid(out_rd_valid),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0), .SUPPRESS_X0(1'b1)) dutAlt (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(alt_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(alt_out_valid), .out_ready(out_ready),
    .out_pc(alt_out_pc), .out_instr_id(alt_out_instr_id), .out_opcode(alt_out_opcode),
    .out_rs1(alt_out_rs1), .out_rs2(alt_out_rs2), .out_rd(alt_out_rd),
    .out_rs1_valid(alt_out_rs1_valid), .out_rs2_valid(alt_out_rs2_valid),
    .out_rd_valid(alt_out_rd_valid), .out_imm(alt_out_imm), .out_illegal(alt_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passes++;
  endtask

  // Caller sits just after a rising edge; the beat is pushed on the negedge before the accepting edge
  task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
    bit fired = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc;
    while (!fired && waited < 40) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        fired = 1'b1;
        sbQ.push_back('{v: v, pc: pc});
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    lastWait = waited;
    if (!fired) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    out_ready = 1'b1;
    while (sbQ.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainLeftover", sbQ.size(), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".out_valid"}, out_valid, 32'd0);
    checkOutput({tag, ".in_ready"}, in_ready, 32'd1);
    checkOutput({tag, ".instr_id"}, out_instr_id, 32'd0);
    checkOutput({tag, ".illegal"}, out_illegal, 32'd0);
    checkOutput({tag, ".imm"}, out_imm, 32'd0);
    checkOutput({tag, ".pc"}, out_pc, 32'd0);
    checkOutput({tag, ".rd_valid"}, out_rd_valid, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedBeat", out_pc, 32'hFFFFFFFF);
      end else begin
        sb_t e;
        e = sbQ.pop_front();
        checkOutput("pc", out_pc, e.pc);
        checkOutput("instr_id", out_instr_id, e.v.id);
        checkOutput("opcode", out_opcode, {25'd0, e.v.instr[6:0]});
        checkOutput("rs1", out_rs1, e.v.rs1);
        checkOutput("rs2", out_rs2, e.v.rs2);
        checkOutput("rd", out_rd, e.v.rd);
        checkOutput("valids", {out_rs1_valid, out_rs2_valid, out_rd_valid}, e.v.vld);
        checkOutput("imm", out_imm, e.v.imm);
        checkOutput("illegal", out_illegal, e.v.id == INSTR_INVALID);
        checkOutput("alt.valid", alt_out_valid, 32'd1);
        checkOutput("alt.instr_id", alt_out_instr_id, e.v.altId);
        checkOutput("alt.illegal", alt_out_illegal, e.v.altId == INSTR_INVALID);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vBad;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;

    //           instr         id             rs1 rs2 rd  vld     imm           altId
    vecs.push_back('{32'h002081B3, INSTR_ADD,     1, 2, 3, 3'b111, 32'h0,        INSTR_ADD});
    vecs.push_back('{32'h022081B3, INSTR_MUL,     1, 2, 3, 3'b111, 32'h0,        INSTR_INVALID});
    vecs.push_back('{32'h40335293, INSTR_SRAI,    6, 0, 5, 3'b101, 32'h403,      INSTR_SRAI});
    vecs.push_back('{32'h00000013, INSTR_ADDI,    0, 0, 0, 3'b100, 32'h0,        INSTR_ADDI});
    vecs.push_back('{32'h300110F3, INSTR_CSRRW,   2, 0, 1, 3'b101, 32'h300,      INSTR_INVALID});
    vecs.push_back('{32'h00000073, INSTR_ECALL,   0, 0, 0, 3'b000, 32'h0,        INSTR_INVALID});
    vecs.push_back('{32'h00000173, INSTR_INVALID, 0, 0, 0, 3'b000, 32'h0,        INSTR_INVALID});
    vecs.push_back('{32'hFFC12283, INSTR_LW,      2, 0, 5, 3'b101, 32'hFFFFFFFC, INSTR_LW});
    vecs.push_back('{32'h0070A423, INSTR_SW,      1, 7, 0, 3'b110, 32'h8,        INSTR_SW});
    vecs.push_back('{32'hFE208CE3, INSTR_BEQ,     1, 2, 0, 3'b110, 32'hFFFFFFF8, INSTR_BEQ});
    vecs.push_back('{32'h001000EF, INSTR_JAL,     0, 0, 1, 3'b001, 32'h800,      INSTR_JAL});
    vecs.push_back('{32'h12345537, INSTR_LUI,     0, 0, 10, 3'b001, 32'h12345000, INSTR_LUI});
    vecs.push_back('{32'h02009093, INSTR_INVALID, 0, 0, 0, 3'b000, 32'h0,        INSTR_INVALID});
    vecs.push_back('{32'h3052D1F3, INSTR_CSRRWI,  5, 0, 3, 3'b001, 32'h305,      INSTR_INVALID});
    vecs.push_back('{32'h30200073, INSTR_MRET,    0, 0, 0, 3'b000, 32'h302,      INSTR_INVALID});
    vecs.push_back('{32'h00100073, INSTR_EBREAK,  0, 0, 0, 3'b000, 32'h1,        INSTR_INVALID});
    vecs.push_back('{32'h00208033, INSTR_ADD,     1, 2, 0, 3'b110, 32'h0,        INSTR_ADD});
    vecs.push_back('{32'h0000100F, INSTR_FENCE_I, 0, 0, 0, 3'b000, 32'h0,        INSTR_FENCE_I});

    #3;
    checkResetOutputs("asyncReset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkResetOutputs("afterReset");

    $display("[TB] single beat latency");
    out_ready = 1'b1;
    applyStimulus(vecs[0], 32'h100);
    checkOutput("latency.out_valid", out_valid, 32'd1);
    checkOutput("latency.instr_id", out_instr_id, INSTR_ADD);
    waitDrain();

    $display("[TB] table stream at full throughput");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], 32'h1000 + 32'(i * 4));
      checkOutput("throughput.cycles", lastWait, 32'd1);
    end
    waitDrain();
    @(posedge clk); #1;
    checkOutput("idle.out_valid", out_valid, 32'd0);

    $display("[TB] backpressure A,B,C,D");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 32'h2000 + 32'(i * 4));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp.in_ready_drop", in_ready, 32'd0);
        checkOutput("bp.holdA.valid", out_valid, 32'd1);
        checkOutput("bp.holdA.pc", out_pc, 32'h2000);
        @(posedge clk);
        #1;
        checkOutput("bp.stableA.pc", out_pc, 32'h2000);
        checkOutput("bp.stableA.id", out_instr_id, INSTR_ADD);
        out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] flush with both entries full");
    out_ready = 1'b0;
    applyStimulus(vecs[2], 32'h3000);
    applyStimulus(vecs[3], 32'h3004);
    checkOutput("flush.pre_in_ready", in_ready, 32'd0);
    in_valid = 1'b1; in_instr = vecs[4].instr; in_pc = 32'h3008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sbQ.delete();
    checkOutput("flush.out_valid", out_valid, 32'd0);
    checkOutput("flush.in_ready", in_ready, 32'd1);

    $display("[TB] flush drops an acceptable incoming beat");
    applyStimulus(vecs[5], 32'h3100);
    in_valid = 1'b1; in_instr = vecs[6].instr; in_pc = 32'h3104; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sbQ.delete();
    checkOutput("flush2.out_valid", out_valid, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush2.quiet", out_valid, 32'd0);
    applyStimulus(vecs[7], 32'h3200);
    waitDrain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(vecs[8], 32'h4000);
    applyStimulus(vecs[9], 32'h4004);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkResetOutputs("midReset");
    checkOutput("midReset.rs1", out_rs1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    vBad = vecs[1];
    applyStimulus(vBad, 32'h5000);
    waitDrain();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
